// File: rtl/bp_clint_timer_array_pkg.sv
// Shared CLINT definitions: default address map and the register decode result type.
package bp_clint_timer_array_pkg;

  localparam int unsigned clint_msip_base_gp     = 32'h0000;
  localparam int unsigned clint_mtimecmp_base_gp = 32'h4000;
  localparam int unsigned clint_mtime_addr_gp    = 32'hBFF8;

  typedef enum logic [1:0] {
    e_clint_msip,
    e_clint_mtimecmp,
    e_clint_mtime,
    e_clint_none
  } bp_clint_dev_e;

  // Index width that stays legal (>= 1 bit) for a single-entry array.
  function automatic int unsigned clint_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_clint_timer_array_if.sv
// Request/response bus of the CLINT; signal names carry their direction as seen by the CLINT.
interface bp_clint_timer_array_if #(
  parameter int unsigned addr_width_p  = 16,
  parameter int unsigned dword_width_p = 64
);

  logic                     v_i;
  logic                     ready_and_o;
  logic                     w_i;
  logic [addr_width_p-1:0]  addr_i;
  logic [dword_width_p-1:0] data_i;
  logic                     v_o;
  logic                     yumi_i;
  logic [dword_width_p-1:0] data_o;

  modport master (
    output v_i, w_i, addr_i, data_i, yumi_i,
    input  ready_and_o, v_o, data_o
  );

  modport slave (
    input  v_i, w_i, addr_i, data_i, yumi_i,
    output ready_and_o, v_o, data_o
  );

endinterface

// File: rtl/bp_clint_addr_decode.sv
// Maps a CLINT byte address onto a register class and hart index; out-of-range harts decode
// as unmapped.
module bp_clint_addr_decode
  import bp_clint_timer_array_pkg::*;
#(
  parameter int unsigned num_harts_p     = 4,
  parameter int unsigned addr_width_p    = 16,
  parameter int unsigned msip_base_p     = clint_msip_base_gp,
  parameter int unsigned mtimecmp_base_p = clint_mtimecmp_base_gp,
  parameter int unsigned mtime_addr_p    = clint_mtime_addr_gp,
  parameter int unsigned hart_width_p    = clint_idx_width(num_harts_p)
) (
  input  logic [addr_width_p-1:0] addr_i,
  output bp_clint_dev_e           dev_o,
  output logic [hart_width_p-1:0] hart_o
);

  localparam int unsigned WordW = addr_width_p - 3;

  localparam logic [WordW-1:0] NumHarts  = WordW'(num_harts_p);
  localparam logic [WordW-1:0] MsipWord  = WordW'(msip_base_p >> 3);
  localparam logic [WordW-1:0] CmpWord   = WordW'(mtimecmp_base_p >> 3);
  localparam logic [WordW-1:0] MtimeWord = WordW'(mtime_addr_p >> 3);

  logic [WordW-1:0] word;
  logic [WordW-1:0] msip_off;
  logic [WordW-1:0] cmp_off;
  logic             unused_low;

  assign word       = addr_i[addr_width_p-1:3];
  assign unused_low = ^addr_i[2:0];

  // An address below the base wraps to a huge offset, so one compare is the full range check.
  assign msip_off = word - MsipWord;
  assign cmp_off  = word - CmpWord;

  always_comb begin
    dev_o  = e_clint_none;
    hart_o = '0;
    if (word == MtimeWord) begin
      dev_o = e_clint_mtime;
    end else if (msip_off < NumHarts) begin
      dev_o  = e_clint_msip;
      hart_o = msip_off[hart_width_p-1:0];
    end else if (cmp_off < NumHarts) begin
      dev_o  = e_clint_mtimecmp;
      hart_o = cmp_off[hart_width_p-1:0];
    end
  end

endmodule

// File: rtl/bp_clint_timer_array.sv
// Core-local interruptor for num_harts_p harts: prescaled shared mtime, per-hart mtimecmp and
// msip, registered timer/software interrupt lines, single-entry response buffer.
module bp_clint_timer_array
  import bp_clint_timer_array_pkg::*;
#(
  parameter int unsigned num_harts_p     = 4,
  parameter int unsigned dword_width_p   = 64,
  parameter int unsigned addr_width_p    = 16,
  parameter int unsigned rtc_div_p       = 8,
  parameter int unsigned mtimecmp_base_p = clint_mtimecmp_base_gp,
  parameter int unsigned mtime_addr_p    = clint_mtime_addr_gp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_clint_timer_array_if.slave  bus_io,
  output logic [num_harts_p-1:0] timer_irq_o,
  output logic [num_harts_p-1:0] software_irq_o
);

  localparam int unsigned HartW = clint_idx_width(num_harts_p);
  localparam int unsigned PsW   = clint_idx_width(rtc_div_p);

  localparam logic [PsW-1:0] PsLast = PsW'(rtc_div_p - 1);

  bp_clint_dev_e                             dev;
  logic [HartW-1:0]                          hart;
  logic                                      accept;
  logic                                      wr_en;
  logic                                      tick;
  logic [dword_width_p-1:0]                  rdata;

  logic [PsW-1:0]                            ps_q, ps_d;
  logic [dword_width_p-1:0]                  mtime_q, mtime_d;
  logic [num_harts_p-1:0][dword_width_p-1:0] mtimecmp_q, mtimecmp_d;
  logic [num_harts_p-1:0]                    msip_q, msip_d;
  logic [num_harts_p-1:0]                    timer_hit;
  logic [num_harts_p-1:0]                    timer_irq_q;
  logic [num_harts_p-1:0]                    software_irq_q;
  logic                                      resp_v_q, resp_v_d;
  logic [dword_width_p-1:0]                  resp_data_q, resp_data_d;

  bp_clint_addr_decode #(
    .num_harts_p     (num_harts_p),
    .addr_width_p    (addr_width_p),
    .msip_base_p     (clint_msip_base_gp),
    .mtimecmp_base_p (mtimecmp_base_p),
    .mtime_addr_p    (mtime_addr_p),
    .hart_width_p    (HartW)
  ) u_decode (
    .addr_i (bus_io.addr_i),
    .dev_o  (dev),
    .hart_o (hart)
  );

  assign bus_io.ready_and_o = ~resp_v_q | bus_io.yumi_i;
  assign bus_io.v_o         = resp_v_q;
  assign bus_io.data_o      = resp_data_q;

  assign accept = bus_io.v_i & bus_io.ready_and_o;
  assign wr_en  = accept & bus_io.w_i;
  assign tick   = (ps_q == PsLast);

  // Prescaler and mtime; a write to mtime wins over a coincident tick.
  always_comb begin
    ps_d    = tick ? '0 : ps_q + PsW'(1);
    mtime_d = mtime_q;
    if (wr_en && (dev == e_clint_mtime)) begin
      mtime_d = bus_io.data_i;
    end else if (tick) begin
      mtime_d = mtime_q + dword_width_p'(1);
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en && (dev == e_clint_mtimecmp)) begin
      mtimecmp_d[hart] = bus_io.data_i;
    end
    if (wr_en && (dev == e_clint_msip)) begin
      msip_d[hart] = bus_io.data_i[0];
    end
  end

  // Reads see the register contents ahead of any update landing on the same edge.
  always_comb begin
    rdata = '0;
    unique case (dev)
      e_clint_msip:     rdata = dword_width_p'(msip_q[hart]);
      e_clint_mtimecmp: rdata = mtimecmp_q[hart];
      e_clint_mtime:    rdata = mtime_q;
      default:          rdata = '0;
    endcase
  end

  always_comb begin
    resp_v_d    = resp_v_q;
    resp_data_d = resp_data_q;
    if (accept) begin
      resp_v_d    = 1'b1;
      resp_data_d = bus_io.w_i ? '0 : rdata;
    end else if (bus_io.yumi_i) begin
      resp_v_d = 1'b0;
    end
  end

  always_comb begin
    timer_hit = '0;
    for (int unsigned h = 0; h < num_harts_p; h++) begin
      timer_hit[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ps_q           <= '0;
      mtime_q        <= '0;
      mtimecmp_q     <= '1;
      msip_q         <= '0;
      timer_irq_q    <= '0;
      software_irq_q <= '0;
      resp_v_q       <= 1'b0;
      resp_data_q    <= '0;
    end else begin
      ps_q           <= ps_d;
      mtime_q        <= mtime_d;
      mtimecmp_q     <= mtimecmp_d;
      msip_q         <= msip_d;
      timer_irq_q    <= timer_hit;
      software_irq_q <= msip_d;
      resp_v_q       <= resp_v_d;
      resp_data_q    <= resp_data_d;
    end
  end

  assign timer_irq_o    = timer_irq_q;
  assign software_irq_o = software_irq_q;

endmodule

// File: tb/tb_bp_clint_timer_array.sv
// Bench for bp_clint_timer_array: directed scenarios plus random traffic, all checked each cycle
// against a tick-counting reference model.
module tb_bp_clint_timer_array;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [N-1:0] tirq;
  logic [N-1:0] sirq;

  int n_chk = 0;
  int n_err = 0;

  bp_clint_timer_array_if #(.addr_width_p(16), .dword_width_p(64)) bus ();

  bp_clint_timer_array #(
    .num_harts_p     (N),
    .dword_width_p   (64),
    .addr_width_p    (16),
    .rtc_div_p       (DIV),
    .mtimecmp_base_p (32'h4000),
    .mtime_addr_p    (32'hBFF8)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .bus_io         (bus),
    .timer_irq_o    (tirq),
    .software_irq_o (sirq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mtime = last written value + ticks since that write, where a tick lands on
  // every DIV-th clock edge counted from reset release (the tick on the write edge is lost).
  logic              m_live = 1'b0;
  int unsigned       m_k, m_kw;
  logic [63:0]       m_base;
  logic [N-1:0][63:0] m_cmp;
  logic [N-1:0]      m_msip, m_tirq, m_sirq;
  logic              m_v;
  logic [63:0]       m_d, m_mt, m_rd;
  logic              m_acc;
  int                m_kind, m_idx;

  function automatic logic [63:0] model_mtime();
    return m_base + 64'(m_k / DIV - m_kw / DIV);
  endfunction

  // kind: 0 msip, 1 mtimecmp, 2 mtime, 3 unmapped
  function automatic void decode(input logic [15:0] a, output int kind, output int idx);
    int al;
    al   = int'(a) & 32'hFFF8;
    kind = 3;
    idx  = 0;
    if (al == 32'hBFF8) kind = 2;
    else if (al < 8 * N) begin kind = 0; idx = al / 8; end
    else if (al >= 32'h4000 && al < 32'h4000 + 8 * N) begin kind = 1; idx = (al - 32'h4000) / 8; end
  endfunction

  always @(posedge clk) begin
    if (reset_i) begin
      m_live = 1'b1;
      m_k = 0; m_kw = 0; m_base = '0;
      for (int h = 0; h < N; h++) m_cmp[h] = '1;
      m_msip = '0; m_tirq = '0; m_sirq = '0; m_v = 1'b0; m_d = '0;
    end else if (m_live) begin
      m_mt  = model_mtime();
      m_acc = bus.v_i && (!m_v || bus.yumi_i);
      for (int h = 0; h < N; h++) m_tirq[h] = (m_mt >= m_cmp[h]);
      m_k++;
      if (m_acc) begin
        decode(bus.addr_i, m_kind, m_idx);
        m_rd = '0;
        if (bus.w_i) begin
          if (m_kind == 0) m_msip[m_idx] = bus.data_i[0];
          else if (m_kind == 1) m_cmp[m_idx] = bus.data_i;
          else if (m_kind == 2) begin m_base = bus.data_i; m_kw = m_k; end
        end else begin
          if (m_kind == 0) m_rd = 64'(m_msip[m_idx]);
          else if (m_kind == 1) m_rd = m_cmp[m_idx];
          else if (m_kind == 2) m_rd = m_mt;
        end
        m_v = 1'b1;
        m_d = m_rd;
      end else if (bus.yumi_i) begin
        m_v = 1'b0;
      end
      m_sirq = m_msip;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("v_o", 64'(bus.v_o), 64'(m_v));
      check("data_o", bus.data_o, m_d);
      check("ready_and_o", 64'(bus.ready_and_o), 64'(!m_v || bus.yumi_i));
      check("timer_irq_o", 64'(tirq), 64'(m_tirq));
      check("software_irq_o", 64'(sirq), 64'(m_sirq));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1);
  end

  // Tasks start and end just after a rising edge.
  task automatic do_reset();
    bus.v_i = 1'b0; bus.yumi_i = 1'b0; reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  task automatic req(input logic w, input logic [15:0] a, input logic [63:0] d,
                     output logic [63:0] rd);
    logic acc;
    int   n;
    bus.v_i = 1'b1; bus.w_i = w; bus.addr_i = a; bus.data_i = d; bus.yumi_i = 1'b0;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.ready_and_o;
      @(posedge clk);
      #1 n++;
    end
    bus.v_i = 1'b0;
    check("req_accepted", 64'(acc), 64'd1);
    rd = '0;
    if (acc) begin
      bus.yumi_i = 1'b1;
      @(negedge clk);
      rd = bus.data_o;
      @(posedge clk);
      #1 bus.yumi_i = 1'b0;
    end
  endtask

  logic [63:0] rd, d;
  logic [15:0] a;
  int          sel, h;

  initial begin
    bus.v_i = 1'b0; bus.w_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.yumi_i = 1'b0;
    reset_i = 1'b1;

    // Reset state of mtimecmp and the timer lines.
    do_reset();
    req(1'b0, 16'h4010, 64'd0, rd);
    check("mtimecmp2_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("timer_irq_idle", 64'(tirq), 64'd0);

    // 80 idle edges at /8 prescale, read accepted on edge 81 sees mtime 10.
    do_reset();
    repeat (80) @(posedge clk);
    #1 req(1'b0, 16'hBFF8, 64'd0, rd);
    check("mtime_after_80", rd, 64'd10);

    // mtime reaches 5 on edge 40; timer_irq_o[1] follows on edge 41.
    do_reset();
    req(1'b1, 16'h4008, 64'd5, rd);
    check("write_resp_zero", rd, 64'd0);
    repeat (38) @(posedge clk);
    @(negedge clk);
    check("timer_irq_before", 64'(tirq), 64'd0);
    @(negedge clk);
    check("timer_irq_hart1", 64'(tirq), 64'b0010);
    @(posedge clk);
    #1;

    // Software interrupts; hart 4 is out of range and must be dropped.
    req(1'b1, 16'h0018, 64'd1, rd);
    check("msip3_set", 64'(sirq), 64'b1000);
    req(1'b0, 16'h0018, 64'd0, rd);
    check("msip3_read", rd, 64'd1);
    req(1'b1, 16'h0018, 64'd0, rd);
    check("msip3_clear", 64'(sirq), 64'd0);
    req(1'b1, 16'h0020, 64'd1, rd);
    check("msip_hart4_dropped", 64'(sirq), 64'd0);

    // Response held under back-pressure, then consume and accept on the same edge.
    req(1'b1, 16'h4018, 64'h1234_5678, rd);
    bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 16'h4018; bus.yumi_i = 1'b0;
    @(posedge clk);
    #1 bus.addr_i = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_v_o", 64'(bus.v_o), 64'd1);
      check("stall_data_o", bus.data_o, 64'h1234_5678);
      check("stall_ready", 64'(bus.ready_and_o), 64'd0);
    end
    @(posedge clk);
    #1 bus.yumi_i = 1'b1;
    @(posedge clk);
    #1 bus.yumi_i = 1'b0; bus.v_i = 1'b0;
    @(negedge clk);
    check("b2b_v_o", 64'(bus.v_o), 64'd1);
    check("b2b_data_o", bus.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 bus.yumi_i = 1'b1;
    @(posedge clk);
    #1 bus.yumi_i = 1'b0;

    // mtime written to all ones on tick edge 8; the next tick (edge 16) wraps it.
    do_reset();
    repeat (7) @(posedge clk);
    #1 req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, rd);
    req(1'b0, 16'hBFF8, 64'd0, rd);
    check("mtime_ones", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    req(1'b0, 16'h8000, 64'd0, rd);
    check("unmapped_read", rd, 64'd0);
    repeat (3) @(posedge clk);
    #1 req(1'b0, 16'hBFF8, 64'd0, rd);
    check("mtime_wrapped", rd, 64'd0);

    // Reset while a response is pending drops it.
    bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 16'h4000;
    @(posedge clk);
    #1 bus.v_i = 1'b0; reset_i = 1'b1;
    @(negedge clk);
    check("pending_before_reset", 64'(bus.v_o), 64'd1);
    @(negedge clk);
    check("pending_dropped", 64'(bus.v_o), 64'd0);
    @(posedge clk);
    #1 reset_i = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset_i = ($urandom_range(0, 399) == 0);
      sel = $urandom_range(0, 5);
      h   = $urandom_range(0, N);
      case (sel)
        0:       a = 16'(8 * h);
        1, 2:    a = 16'(32'h4000 + 8 * h);
        3:       a = 16'hBFF8;
        default: a = 16'($urandom);
      endcase
      a[2:0] = 3'($urandom);
      d = {$urandom, $urandom};
      if (sel == 0) d = 64'($urandom_range(0, 3));
      if (sel == 1 || sel == 2) d = model_mtime() + 64'($urandom_range(0, 6));
      if (sel == 3 && $urandom_range(0, 2) == 0) d = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      if (sel == 3 && $urandom_range(0, 2) == 0) d = 64'($urandom_range(0, 20));
      bus.v_i    = ($urandom_range(0, 2) != 0);
      bus.w_i    = 1'($urandom_range(0, 1));
      bus.addr_i = a;
      bus.data_i = d;
      bus.yumi_i = !reset_i && m_v && ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    bus.v_i = 1'b0; bus.yumi_i = 1'b0; reset_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
